// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MA outputs of the execute stage.
// slave is the stage itself; master is whoever drives it.
interface ex_stage_if;
  logic        valid_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] pc_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic [4:0]  addr_rs1_i;
  logic [4:0]  addr_rs2_i;
  logic [4:0]  addr_d_i;
  logic [3:0]  alu_op_i;
  logic        src_a_sel_i;
  logic        src_b_sel_i;
  logic        branch_i;
  logic        jump_i;
  logic        jalr_i;
  logic        reg_we_i;
  logic        mem_we_i;
  logic        mem_re_i;
  logic [1:0]  wb_sel_i;
  logic [2:0]  funct3_i;
  logic [6:0]  opcode_i;
  logic        wb_we_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        reg_we_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [1:0]  wb_sel_o;
  logic [2:0]  funct3_o;
  logic [6:0]  opcode_o;
  logic [4:0]  addr_d_o;
  logic [31:0] alu_result_o;
  logic [31:0] data_w_o;
  logic [31:0] pc4_o;
  logic        redirect_o;
  logic [31:0] target_o;

  modport slave (
    input  valid_i, stall_i, flush_i, pc_i,
    input  rs1_data_i, rs2_data_i, imm_i,
    input  addr_rs1_i, addr_rs2_i, addr_d_i,
    input  alu_op_i, src_a_sel_i, src_b_sel_i,
    input  branch_i, jump_i, jalr_i,
    input  reg_we_i, mem_we_i, mem_re_i,
    input  wb_sel_i, funct3_i, opcode_i,
    input  wb_we_i, wb_addr_i, wb_data_i,
    output reg_we_o, mem_we_o, mem_re_o,
    output wb_sel_o, funct3_o, opcode_o,
    output addr_d_o, alu_result_o, data_w_o,
    output pc4_o, redirect_o, target_o
  );

  modport master (
    output valid_i, stall_i, flush_i, pc_i,
    output rs1_data_i, rs2_data_i, imm_i,
    output addr_rs1_i, addr_rs2_i, addr_d_i,
    output alu_op_i, src_a_sel_i, src_b_sel_i,
    output branch_i, jump_i, jalr_i,
    output reg_we_i, mem_we_i, mem_re_i,
    output wb_sel_i, funct3_i, opcode_i,
    output wb_we_i, wb_addr_i, wb_data_i,
    input  reg_we_o, mem_we_o, mem_re_o,
    input  wb_sel_o, funct3_o, opcode_o,
    input  addr_d_o, alu_result_o, data_w_o,
    input  pc4_o, redirect_o, target_o
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch resolution
// and the EX/MA pipeline register.
module ex_stage #(
  parameter bit ENABLE_FWD = 1'b1
) (
  input logic      clk,
  input logic      rst,
  ex_stage_if.slave bus
);

  logic        reg_we_q, reg_we_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [4:0]  addr_d_q, addr_d_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] dw_q, dw_d;
  logic [31:0] pc4_q, pc4_d;

  logic [31:0] rs1_fwd, rs2_fwd;
  logic [31:0] op_a, op_b, alu_res;
  logic [31:0] ex_val;
  logic        ex_ok, wb_ok;
  logic [4:0]  shamt;
  logic        taken;
  logic [31:0] jalr_sum;

  // Loads in EX/MA are not a forwarding source; the hazard
  // unit stalls those instead.
  assign ex_ok = reg_we_q && (addr_d_q != 5'd0) &&
                 ((wb_sel_q == 2'b00) || (wb_sel_q == 2'b10));
  assign ex_val = (wb_sel_q == 2'b10) ? pc4_q : alu_q;
  assign wb_ok = bus.wb_we_i && (bus.wb_addr_i != 5'd0);

  // Operand forwarding: EX/MA first, then writeback.
  always_comb begin
    rs1_fwd = bus.rs1_data_i;
    rs2_fwd = bus.rs2_data_i;
    if (ENABLE_FWD) begin
      if (ex_ok && addr_d_q == bus.addr_rs1_i)
        rs1_fwd = ex_val;
      else if (wb_ok && bus.wb_addr_i == bus.addr_rs1_i)
        rs1_fwd = bus.wb_data_i;
      if (ex_ok && addr_d_q == bus.addr_rs2_i)
        rs2_fwd = ex_val;
      else if (wb_ok && bus.wb_addr_i == bus.addr_rs2_i)
        rs2_fwd = bus.wb_data_i;
    end
  end

  assign op_a  = bus.src_a_sel_i ? bus.pc_i : rs1_fwd;
  assign op_b  = bus.src_b_sel_i ? bus.imm_i : rs2_fwd;
  assign shamt = op_b[4:0];

  // ALU; unused opcodes yield zero.
  always_comb begin
    alu_res = 32'd0;
    case (bus.alu_op_i)
      4'd0:  alu_res = op_a + op_b;
      4'd1:  alu_res = op_a - op_b;
      4'd2:  alu_res = op_a << shamt;
      4'd3:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      4'd4:  alu_res = {31'd0, op_a < op_b};
      4'd5:  alu_res = op_a ^ op_b;
      4'd6:  alu_res = op_a >> shamt;
      4'd7:  alu_res = $unsigned($signed(op_a) >>> shamt);
      4'd8:  alu_res = op_a | op_b;
      4'd9:  alu_res = op_a & op_b;
      4'd10: alu_res = op_b;
      default: alu_res = 32'd0;
    endcase
  end

  // Branch condition on forwarded register operands.
  always_comb begin
    taken = 1'b0;
    case (bus.funct3_i)
      3'b000: taken = (rs1_fwd == rs2_fwd);
      3'b001: taken = (rs1_fwd != rs2_fwd);
      3'b100: taken = ($signed(rs1_fwd) < $signed(rs2_fwd));
      3'b101: taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      3'b110: taken = (rs1_fwd < rs2_fwd);
      3'b111: taken = (rs1_fwd >= rs2_fwd);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum = rs1_fwd + bus.imm_i;
  assign bus.target_o = bus.jalr_i ? {jalr_sum[31:1], 1'b0}
                                   : bus.pc_i + bus.imm_i;
  assign bus.redirect_o = ~rst & bus.valid_i & ~bus.stall_i &
                          ~bus.flush_i &
                          (bus.jump_i | (bus.branch_i & taken));

  // Next EX/MA contents; invalid or flushed slots become bubbles.
  always_comb begin
    reg_we_d = 1'b0;
    mem_we_d = 1'b0;
    mem_re_d = 1'b0;
    wb_sel_d = 2'b00;
    funct3_d = 3'd0;
    opcode_d = 7'd0;
    addr_d_d = 5'd0;
    alu_d    = 32'd0;
    dw_d     = 32'd0;
    pc4_d    = 32'd0;
    if (bus.valid_i && !bus.flush_i) begin
      reg_we_d = bus.reg_we_i && (bus.addr_d_i != 5'd0);
      mem_we_d = bus.mem_we_i;
      mem_re_d = bus.mem_re_i;
      wb_sel_d = bus.wb_sel_i;
      funct3_d = bus.funct3_i;
      opcode_d = bus.opcode_i;
      addr_d_d = bus.addr_d_i;
      alu_d    = alu_res;
      dw_d     = rs2_fwd;
      pc4_d    = bus.pc_i + 32'd4;
    end
  end

  // EX/MA register; stall holds it, flush is ignored under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_we_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      wb_sel_q <= 2'b00;
      funct3_q <= 3'd0;
      opcode_q <= 7'd0;
      addr_d_q <= 5'd0;
      alu_q    <= 32'd0;
      dw_q     <= 32'd0;
      pc4_q    <= 32'd0;
    end else if (!bus.stall_i) begin
      reg_we_q <= reg_we_d;
      mem_we_q <= mem_we_d;
      mem_re_q <= mem_re_d;
      wb_sel_q <= wb_sel_d;
      funct3_q <= funct3_d;
      opcode_q <= opcode_d;
      addr_d_q <= addr_d_d;
      alu_q    <= alu_d;
      dw_q     <= dw_d;
      pc4_q    <= pc4_d;
    end
  end

  assign bus.reg_we_o     = reg_we_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_re_o     = mem_re_q;
  assign bus.wb_sel_o     = wb_sel_q;
  assign bus.funct3_o     = funct3_q;
  assign bus.opcode_o     = opcode_q;
  assign bus.addr_d_o     = addr_d_q;
  assign bus.alu_result_o = alu_q;
  assign bus.data_w_o     = dw_q;
  assign bus.pc4_o        = pc4_q;

endmodule
